// File: rtl/sweep_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sweep_sequencer                                              |
// | Description : Sequences a one-hot LED sweep pattern. A start request in    |
// |               IDLE latches mode/rate/sweeps. The run then steps the        |
// |               pattern every rate+1 unpaused cycles (bounce, rotate-left    |
// |               or rotate-right). It completes after the requested number of |
// |               sweeps, or runs forever when sweeps is 0.                    |
// | Ports       : clk, reset      - clock, synchronous active-high reset       |
// |               start           - run request, honoured only in IDLE         |
// |               pause           - freezes prescaler/pattern while in RUN     |
// |               mode[1:0]       - 0/3 bounce, 1 rotate left, 2 rotate right  |
// |               rate[DIV_W-1:0] - cycles between steps minus one             |
// |               sweeps[7:0]     - sweeps per run, 0 = unlimited              |
// |               pattern         - one-hot display pattern                    |
// |               step            - high the cycle after each pattern update   |
// |               sweep_cnt[7:0]  - completed sweeps in the current run        |
// |               busy / done     - RUN indicator / one-cycle completion pulse |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sweep_sequencer #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] rate,
    input  logic [7:0]       sweeps,
    output logic [WIDTH-1:0] pattern,
    output logic             step,
    output logic [7:0]       sweep_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0]       c_MODE_ROTL = 2'd1;
    localparam logic [1:0]       c_MODE_ROTR = 2'd2;
    localparam logic [WIDTH-1:0] c_BIT0      = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_next;

    logic [1:0]       r_mode;
    logic [DIV_W-1:0] r_rate;
    logic [7:0]       r_sweeps;
    logic [DIV_W-1:0] r_presc;
    logic [WIDTH-1:0] r_pattern;
    logic             r_dir_right;
    logic [7:0]       r_sweep_cnt;
    logic             r_step;

    logic [WIDTH-1:0] w_pattern_next;
    logic             w_dir_right_next;
    logic             w_start_run;
    logic             w_step_now;
    logic             w_lands_bit0;
    logic             w_last_sweep;

    // The prescaler only counts up to the latched rate and then clears, so the
    // full DIV_W range (rate = all ones) never overflows.
    assign w_start_run  = (r_state == S_IDLE) && start;
    assign w_step_now   = (r_state == S_RUN) && !pause && (r_presc == r_rate);
    assign w_lands_bit0 = (w_pattern_next == c_BIT0);
    // 8-bit compare: a wrapped count (255 -> 0) can never equal a nonzero target.
    assign w_last_sweep = (r_sweeps != 8'd0) && w_lands_bit0
                          && ((r_sweep_cnt + 8'd1) == r_sweeps);

    // Next pattern for one step. In bounce mode the direction flips at the
    // end bits before the shift, so the pattern never leaves the register.
    always_comb begin
        w_pattern_next   = r_pattern;
        w_dir_right_next = r_dir_right;
        case (r_mode)
            c_MODE_ROTL: w_pattern_next = {r_pattern[WIDTH-2:0], r_pattern[WIDTH-1]};
            c_MODE_ROTR: w_pattern_next = {r_pattern[0], r_pattern[WIDTH-1:1]};
            default: begin
                if (r_pattern[WIDTH-1]) begin
                    w_dir_right_next = 1'b1;
                end else if (r_pattern[0]) begin
                    w_dir_right_next = 1'b0;
                end
                w_pattern_next = w_dir_right_next ? (r_pattern >> 1) : (r_pattern << 1);
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_step_now && w_last_sweep) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shadow registers, prescaler, pattern and sweep counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode      <= 2'd0;
            r_rate      <= '0;
            r_sweeps    <= 8'd0;
            r_presc     <= '0;
            r_pattern   <= c_BIT0;
            r_dir_right <= 1'b0;
            r_sweep_cnt <= 8'd0;
            r_step      <= 1'b0;
        end else if (w_start_run) begin
            r_mode      <= mode;
            r_rate      <= rate;
            r_sweeps    <= sweeps;
            r_presc     <= '0;
            r_pattern   <= c_BIT0;
            r_dir_right <= 1'b0;
            r_sweep_cnt <= 8'd0;
            r_step      <= 1'b0;
        end else begin
            r_step <= w_step_now;
            if ((r_state == S_RUN) && !pause) begin
                if (r_presc == r_rate) begin
                    r_presc     <= '0;
                    r_pattern   <= w_pattern_next;
                    r_dir_right <= w_dir_right_next;
                    if (w_lands_bit0) begin
                        r_sweep_cnt <= r_sweep_cnt + 8'd1;
                    end
                end else begin
                    r_presc <= r_presc + DIV_W'(1);
                end
            end
        end
    end

    assign pattern   = r_pattern;
    assign step      = r_step;
    assign sweep_cnt = r_sweep_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sweep_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sweep_sequencer                                           |
// | Description : Self-checking bench for sweep_sequencer. Drives directed and |
// |               random stimulus cycle by cycle and compares every output     |
// |               after each clock edge against a step-count reference model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sweep_sequencer;

    localparam int W  = 8;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          pause;
    logic [1:0]    mode;
    logic [DW-1:0] rate;
    logic [7:0]    sweeps;
    logic [W-1:0]  pattern;
    logic          step;
    logic [7:0]    sweep_cnt;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the pattern position is a function of the number of
    // steps taken; steps happen every (rate+1) unpaused RUN cycles.
    int m_state  = 0;   // 0 idle, 1 run, 2 done
    int m_steps  = 0;
    int m_active = 0;
    int m_mode   = 0;
    int m_rate   = 0;
    int m_sweeps = 0;
    bit m_step   = 1'b0;

    always #5 clk = ~clk;

    sweep_sequencer #(
        .WIDTH (W),
        .DIV_W (DW)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pause     (pause),
        .mode      (mode),
        .rate      (rate),
        .sweeps    (sweeps),
        .pattern   (pattern),
        .step      (step),
        .sweep_cnt (sweep_cnt),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sweep_len(input int md);
        return (md == 1 || md == 2) ? W : 2 * (W - 1);
    endfunction

    function automatic logic [W-1:0] exp_pattern();
        int len;
        int s;
        int pos;
        logic [W-1:0] p;
        len = sweep_len(m_mode);
        s   = m_steps % len;
        if (m_mode == 1)      pos = s;
        else if (m_mode == 2) pos = (W - s) % W;
        else                  pos = (s <= W - 1) ? s : len - s;
        p      = '0;
        p[pos] = 1'b1;
        return p;
    endfunction

    task automatic model_edge(input int r, input int st, input int ps,
                              input int md, input int rt, input int sw);
        if (r != 0) begin
            m_state  = 0;
            m_steps  = 0;
            m_active = 0;
            m_step   = 1'b0;
            m_mode   = 0;
        end else begin
            case (m_state)
                0: begin
                    m_step = 1'b0;
                    if (st != 0) begin
                        m_mode   = md;
                        m_rate   = rt;
                        m_sweeps = sw;
                        m_steps  = 0;
                        m_active = 0;
                        m_state  = 1;
                    end
                end
                1: begin
                    m_step = 1'b0;
                    if (ps == 0) begin
                        m_active++;
                        if (m_active % (m_rate + 1) == 0) begin
                            m_steps++;
                            m_step = 1'b1;
                            if (m_sweeps != 0 && m_steps == m_sweeps * sweep_len(m_mode))
                                m_state = 2;
                        end
                    end
                end
                default: begin
                    m_step  = 1'b0;
                    m_state = 0;
                end
            endcase
        end
    endtask

    task automatic compare_all();
        check("pattern",   32'(pattern),   32'(exp_pattern()));
        check("step",      32'(step),      32'(m_step));
        check("sweep_cnt", 32'(sweep_cnt), 32'((m_steps / sweep_len(m_mode)) % 256));
        check("busy",      32'(busy),      32'(m_state == 1));
        check("done",      32'(done),      32'(m_state == 2));
    endtask

    // One clock: drive inputs, advance the model, sample after the edge.
    task automatic cycle(input int r, input int st, input int ps,
                         input int md, input int rt, input int sw);
        reset  = (r != 0);
        start  = (st != 0);
        pause  = (ps != 0);
        mode   = 2'(md);
        rate   = DW'(rt);
        sweeps = 8'(sw);
        model_edge(r, st, ps, md, rt, sw);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        pause  = 1'b0;
        mode   = 2'd0;
        rate   = '0;
        sweeps = 8'd0;

        // Reset, then idle
        for (int i = 0; i < 3; i++)  cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 0);

        // Bounce, rate 0, one sweep; input changes during the run are ignored
        cycle(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++)
            cycle(0, 0, 0, int'($urandom_range(3)), int'($urandom_range(15)), int'($urandom_range(255)));

        // Rotate left, rate 3, two sweeps
        cycle(0, 1, 0, 1, 3, 2);
        for (int i = 0; i < 70; i++) cycle(0, 0, 0, 0, 0, 0);

        // Rotate right with a 5-cycle pause after the third step
        cycle(0, 1, 0, 2, 0, 1);
        for (int i = 0; i < 3; i++)  cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)  cycle(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, 0);

        // Bounce, reset mid-run at 0x10 while start toggles
        cycle(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, i % 2, 0, 0, 0, 1);
        check("mid_run_pattern", 32'(pattern), 32'h10);
        cycle(1, 0, 0, 0, 0, 0);
        check("after_reset_pattern", 32'(pattern), 32'h01);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);

        // Maximum prescaler rate
        cycle(0, 1, 0, 1, (1 << DW) - 1, 1);
        for (int i = 0; i < W * (1 << DW) + 5; i++) cycle(0, 0, 0, 0, 0, 0);

        // Unlimited run: 300 sweeps, counter wraps, never done
        cycle(0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 300 * W; i++) cycle(0, int'($urandom_range(1)), 0, 0, 0, 0);
        check("wrapped_cnt", 32'(sweep_cnt), 32'(300 % 256));
        cycle(1, 0, 0, 0, 0, 0);

        // Random operation
        for (int i = 0; i < 3000; i++) begin
            int r_rst;
            int r_sw;
            int r_rt;
            r_rst = ($urandom_range(999) == 0) ? 1 : 0;
            r_sw  = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(3, 1));
            r_rt  = ($urandom_range(9) == 0) ? (1 << DW) - 1 : int'($urandom_range(3));
            cycle(r_rst,
                  ($urandom_range(7) == 0) ? 1 : 0,
                  ($urandom_range(3) == 0) ? 1 : 0,
                  int'($urandom_range(3)),
                  r_rt,
                  r_sw);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
- Controller that sequences the 8-bit one-hot shift register used for the LED sweep display: start/busy/done handshake, programmable step rate, selectable shift mode, fixed number of sweeps.
- Sits between the board control logic (buttons/switches) and the LED bank.
- Owns the one-hot pattern register internally.

Parameters:
- WIDTH, 8, pattern width (one-hot, >= 2)
- DIV_W, 16, width of the step-rate prescaler

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  request a run; sampled only in IDLE
- pause  input  1  level; freezes prescaler and pattern while high in RUN
- mode  input  2  0 bounce, 1 rotate left, 2 rotate right, 3 treated as bounce
- rate  input  DIV_W  cycles between steps minus one (0 = step every cycle)
- sweeps  input  8  sweeps per run; 0 = run until reset
- pattern  output  WIDTH  one-hot display pattern
- step  output  1  high in the cycle following each pattern update edge
- sweep_cnt  output  8  completed sweeps in current run
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse at run completion

Behaviour:
- Reset values: pattern = 1 (bit 0), busy = 0, done = 0, step = 0, sweep_cnt = 0, state = IDLE, direction = left, prescaler = 0. Reset overrides every other input, including mid-run.
- FSM states: IDLE, RUN, DONE.
- IDLE: pattern holds.
  - start=1 at edge k: latch mode, rate, sweeps into shadow registers; pattern=1; direction=left; prescaler=0; sweep_cnt=0; state=RUN (busy=1 after edge k).
  - Input changes during a run are ignored.
- RUN, prescaler: each edge with pause=0, prescaler increments.
  - When prescaler == latched rate, prescaler clears and the pattern steps.
  - First step therefore occurs at edge k+1+rate.
- RUN, pause: pause=1 holds prescaler, pattern and sweep_cnt unchanged. The run is stretched by exactly the number of paused cycles.
- Step rules:
  - mode 0: shift toward current direction. At bit WIDTH-1 the direction becomes right, and at bit 0 it becomes left, both before shifting. A sweep is 2*(WIDTH-1) steps.
  - mode 1: rotate left, bit WIDTH-1 -> bit 0. A sweep is WIDTH steps.
  - mode 2: rotate right, bit 0 -> bit WIDTH-1. A sweep is WIDTH steps.
- Sweep completion: a step that lands pattern on bit 0 completes a sweep.
  - sweep_cnt increments with wrap at 255. With sweeps=0 this never terminates the run.
  - If latched sweeps != 0 and sweep_cnt+1 == sweeps, state = DONE on that same edge.
- DONE: lasts exactly one cycle with done=1 and busy=0; then IDLE.
  - start during DONE is ignored.
  - pattern stays at bit 0; sweep_cnt holds its final value until the next start.
- step is registered: high for one cycle after every step edge. It coincides with done on the final step.
- start while busy is ignored.
- pattern is one-hot at all times after reset.
- Prescaler width arithmetic is unsigned DIV_W bits; rate = 2^DIV_W-1 must work without overflow.

Test Plan:
- Reset, hold idle 10 cycles -> pattern=0x01, busy=0, done=0, step=0, sweep_cnt=0 throughout.
- start at edge k, mode=0, rate=0, sweeps=1:
  - pattern 0x02,0x04,...,0x80,0x40,...,0x01 on edges k+1..k+14.
  - step high each of those cycles; done=1 and busy=0 only after edge k+14; IDLE after k+15.
- start, mode=1, rate=3, sweeps=2:
  - one step every 4 cycles; 0x80 -> 0x01 wraps; sweep_cnt=1 after edge k+32.
  - done after edge k+64, sweep_cnt=2.
- mode=2, rate=0, sweeps=1, pause held high 5 cycles after the 3rd step:
  - pattern 0x80,0x40,0x20 then frozen at 0x20 for 5 cycles.
  - done after edge k+13 instead of k+8.
- Reset asserted mid-run at pattern 0x10 (mode 0) -> after that edge pattern=0x01, busy=0, sweep_cnt=0. start toggled while busy has no effect on timing or count.
- sweeps=0, mode=1, rate=0 -> busy stays 1 for 300 sweeps, sweep_cnt wraps 255->0, done never asserts.
